// File: rtl/fnd_bcd_converter.sv
// Iterative binary-to-BCD converter (shift-add-3, one bit per clock) with a
// start/busy/done handshake, saturation, leading-zero blanking and a digit read port.
module fnd_bcd_converter #(
  parameter int DATA_W = 14,
  parameter int DIGITS = 4,
  parameter int SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [SEL_W-1:0]      i_fndDigit,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_blank,
  output logic                  o_overflow,
  output logic [3:0]            o_fndData
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  function automatic logic [63:0] maxDecimal(input int numDigits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < numDigits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0]       MAX_VAL   = maxDecimal(DIGITS);
  // Zero must still show as a single "0", so digit 0 is never blanked.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] shiftReg;
  logic [BCD_W-1:0]  bcdAcc;
  logic [CNT_W-1:0]  bitCnt;
  logic              ovfPending;

  logic              inputOvf;
  logic [DATA_W-1:0] loadValue;
  logic [BCD_W-1:0]  adjusted;
  logic [BCD_W-1:0]  bcdNext;
  logic [DATA_W-1:0] shiftNext;
  logic [DIGITS-1:0] blankNext;
  logic              upperZero;

  // Saturating load: anything above the displayable range converts as all nines.
  assign inputOvf  = 64'(i_data) > MAX_VAL;
  assign loadValue = inputOvf ? DATA_W'(MAX_VAL) : i_data;

  // NOTE: every signal driven in always_comb gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    adjusted = bcdAcc;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcdAcc[4*k +: 4] >= 4'd5) adjusted[4*k +: 4] = bcdAcc[4*k +: 4] + 4'd3;
    end
    {bcdNext, shiftNext} = {adjusted[BCD_W-2:0], shiftReg, 1'b0};
  end

  // Blank a digit only when it and every digit above it are zero.
  always_comb begin
    blankNext = '0;
    upperZero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upperZero    = upperZero && (bcdAcc[4*k +: 4] == 4'd0);
      blankNext[k] = upperZero;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bcdAcc     <= '0;
      bitCnt     <= '0;
      ovfPending <= 1'b0;
      o_done     <= 1'b0;
      o_bcd      <= '0;
      o_blank    <= BLANK_RST;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            shiftReg   <= loadValue;
            bcdAcc     <= '0;
            bitCnt     <= CNT_W'(DATA_W);
            ovfPending <= inputOvf;
            state      <= CONV;
          end
        end
        CONV: begin
          bcdAcc   <= bcdNext;
          shiftReg <= shiftNext;
          bitCnt   <= bitCnt - CNT_W'(1);
          if (bitCnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          // Publish results only here so outputs never show partial sums.
          o_bcd      <= bcdAcc;
          o_blank    <= blankNext;
          o_overflow <= ovfPending;
          o_done     <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

  always_comb begin
    o_fndData = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i_fndDigit == SEL_W'(k)) o_fndData = o_bcd[4*k +: 4];
    end
  end

endmodule

// File: tb/tb_fnd_bcd_converter.sv
// Self-checking bench: table vectors, random values against a decimal model,
// handshake corner cases, and an exhaustive sweep of an 8-bit / 3-digit instance.
module tb_fnd_bcd_converter;

  logic        clk;
  logic        rstN;
  logic        startA;
  logic [13:0] dataA;
  logic [1:0]  digA;
  logic        busyA, doneA, ovfA;
  logic [15:0] bcdA;
  logic [3:0]  blankA;
  logic [3:0]  fndA;

  logic        startB;
  logic [7:0]  dataB;
  logic [1:0]  digB;
  logic        busyB, doneB, ovfB;
  logic [11:0] bcdB;
  logic [2:0]  blankB;
  logic [3:0]  fndB;

  int nChecks = 0;
  int nErrors = 0;
  logic [15:0] prevBcdA = '0;

  fnd_bcd_converter #(.DATA_W(14), .DIGITS(4)) dutA (
    .i_clk(clk), .i_reset(rstN), .i_start(startA), .i_data(dataA),
    .i_fndDigit(digA), .o_busy(busyA), .o_done(doneA), .o_bcd(bcdA),
    .o_blank(blankA), .o_overflow(ovfA), .o_fndData(fndA)
  );

  fnd_bcd_converter #(.DATA_W(8), .DIGITS(3)) dutB (
    .i_clk(clk), .i_reset(rstN), .i_start(startB), .i_data(dataB),
    .i_fndDigit(digB), .o_busy(busyB), .o_done(doneB), .o_bcd(bcdB),
    .o_blank(blankB), .o_overflow(ovfB), .o_fndData(fndB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference model: saturate, then split with plain arithmetic.
  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic longint satValue(input longint v, input int digits);
    return (v > pow10(digits) - 1) ? pow10(digits) - 1 : v;
  endfunction

  function automatic logic [63:0] modelBcd(input longint v, input int digits);
    logic [63:0] r = '0;
    longint s = satValue(v, digits);
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] modelBlank(input longint v, input int digits);
    logic [63:0] r = '0;
    longint s = satValue(v, digits);
    for (int k = 1; k < digits; k++) r[k] = (s < pow10(k));
    return r;
  endfunction

  task automatic convA(input logic [13:0] v, input logic [15:0] eBcd, input logic [3:0] eBlank,
                       input logic eOvf, input string tag);
    int n = 0;
    int busyLow = 0;
    int holdBad = 0;
    bit seen = 0;
    @(negedge clk);
    dataA = v;
    startA = 1'b1;
    @(posedge clk);
    #1 startA = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (doneA) seen = 1;
      else begin
        if (!busyA) busyLow++;
        if (bcdA !== prevBcdA) holdBad++;
      end
    end
    check({tag, " latency"}, 64'(n), 64'd15);
    check({tag, " busy low while converting"}, 64'(busyLow), 64'd0);
    check({tag, " result held during conversion"}, 64'(holdBad), 64'd0);
    check({tag, " busy in done cycle"}, 64'(busyA), 64'd0);
    check({tag, " bcd"}, 64'(bcdA), 64'(eBcd));
    check({tag, " blank"}, 64'(blankA), 64'(eBlank));
    check({tag, " overflow"}, 64'(ovfA), 64'(eOvf));
    @(posedge clk);
    #1 check({tag, " done width"}, 64'(doneA), 64'd0);
    prevBcdA = eBcd;
  endtask

  task automatic convB(input logic [7:0] v);
    int n = 0;
    bit seen = 0;
    @(negedge clk);
    dataB = v;
    startB = 1'b1;
    @(posedge clk);
    #1 startB = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk);
      #1 n++;
      if (doneB) seen = 1;
    end
    check($sformatf("sweep %0d latency", v), 64'(n), 64'd9);
    check($sformatf("sweep %0d bcd", v), 64'(bcdB), modelBcd(longint'(v), 3) & 64'hfff);
    check($sformatf("sweep %0d blank", v), 64'(blankB), modelBlank(longint'(v), 3));
    check($sformatf("sweep %0d overflow", v), 64'(ovfB), 64'd0);
  endtask

  typedef struct {
    int unsigned value;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int dones;
    int busyLow;
    int firstDone;
    int secondDone;
    logic [13:0] rv;

    vecs[0] = '{1234,  16'h1234, 4'b0000, 1'b0};
    vecs[1] = '{7,     16'h0007, 4'b1110, 1'b0};
    vecs[2] = '{0,     16'h0000, 4'b1110, 1'b0};
    vecs[3] = '{16383, 16'h9999, 4'b0000, 1'b1};
    vecs[4] = '{9999,  16'h9999, 4'b0000, 1'b0};
    vecs[5] = '{10000, 16'h9999, 4'b0000, 1'b1};
    vecs[6] = '{1000,  16'h1000, 4'b0000, 1'b0};
    vecs[7] = '{10,    16'h0010, 4'b1100, 1'b0};
    vecs[8] = '{99,    16'h0099, 4'b1100, 1'b0};
    vecs[9] = '{100,   16'h0100, 4'b1000, 1'b0};

    rstN = 1'b0;
    startA = 1'b0; dataA = '0; digA = '0;
    startB = 1'b0; dataB = '0; digB = '0;
    #12;
    check("reset busy", 64'(busyA), 64'd0);
    check("reset done", 64'(doneA), 64'd0);
    check("reset bcd", 64'(bcdA), 64'd0);
    check("reset blank", 64'(blankA), 64'b1110);
    check("reset overflow", 64'(ovfA), 64'd0);
    check("reset fnd", 64'(fndA), 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 10; i++)
      convA(14'(vecs[i].value), vecs[i].bcd, vecs[i].blank, vecs[i].ovf, $sformatf("vec %0d", vecs[i].value));

    // Digit read port over a known result.
    convA(14'd1234, 16'h1234, 4'b0000, 1'b0, "fnd 1234");
    for (int k = 0; k < 4; k++) begin
      digA = 2'(k);
      #1 check($sformatf("fnd digit %0d", k), 64'(fndA), 64'((1234 / pow10(k)) % 10));
    end
    digA = '0;

    // A start pulse in the middle of a conversion is dropped.
    @(negedge clk);
    dataA = 14'd305;
    startA = 1'b1;
    @(posedge clk);
    #1 startA = 1'b0;
    dones = 0; busyLow = 0; firstDone = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (doneA) begin
        dones++;
        if (firstDone < 0) firstDone = n;
      end else if (n < 15 && !busyA) busyLow++;
      if (n == 5) begin dataA = 14'd42; startA = 1'b1; end
      if (n == 6) startA = 1'b0;
    end
    check("ignored start done count", 64'(dones), 64'd1);
    check("ignored start latency", 64'(firstDone), 64'd15);
    check("ignored start busy", 64'(busyLow), 64'd0);
    check("ignored start bcd", 64'(bcdA), 64'h0305);
    check("ignored start blank", 64'(blankA), 64'b1000);
    prevBcdA = 16'h0305;

    // Start held high: results arrive every DATA_W+2 cycles.
    @(negedge clk);
    dataA = 14'd2468;
    startA = 1'b1;
    firstDone = -1; secondDone = -1;
    for (int n = 1; n <= 60 && secondDone < 0; n++) begin
      @(posedge clk);
      #1;
      if (doneA) begin
        if (firstDone < 0) firstDone = n;
        else begin
          secondDone = n;
          startA = 1'b0;
        end
      end
    end
    startA = 1'b0;
    check("back-to-back period", 64'(secondDone - firstDone), 64'd16);
    check("back-to-back bcd", 64'(bcdA), 64'h2468);
    prevBcdA = 16'h2468;
    repeat (20) @(posedge clk);

    // Asynchronous reset mid-conversion aborts with no done pulse.
    @(negedge clk);
    dataA = 14'd4321;
    startA = 1'b1;
    @(posedge clk);
    #1 startA = 1'b0;
    repeat (8) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    check("abort busy", 64'(busyA), 64'd0);
    check("abort bcd", 64'(bcdA), 64'd0);
    check("abort blank", 64'(blankA), 64'b1110);
    @(negedge clk);
    rstN = 1'b1;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1 if (doneA) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    prevBcdA = '0;
    convA(14'd4321, 16'h4321, 4'b0000, 1'b0, "after abort");

    // Random values against the decimal model.
    for (int i = 0; i < 24; i++) begin
      rv = (i % 2 == 0) ? 14'($urandom_range(0, 16383)) : 14'($urandom_range(0, 9999));
      convA(rv, 16'(modelBcd(longint'(rv), 4)), 4'(modelBlank(longint'(rv), 4)),
            longint'(rv) > 9999, $sformatf("rand %0d", rv));
    end

    // Small instance: exhaustive sweep.
    for (int v = 0; v < 256; v++) convB(8'(v));
    digB = 2'd2;
    #1 check("sweep fnd digit 2", 64'(fndB), 64'd2);
    digB = 2'd3;
    #1 check("sweep fnd out of range", 64'(fndB), 64'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/fnd_bcd_converter.md
Name: fnd_bcd_converter

Overview:
- Parametrised, clocked successor to the combinational FND digit coder.
- Converts a DATA_W-bit unsigned binary value to DIGITS packed BCD digits using an iterative shift-add-3 (double dabble) engine, one bit per clock. No dividers.
- Adds a start/busy/done handshake, a registered result, overflow saturation, a leading-zero blank mask, and a digit-select read port.
- Sits between the PWM/counter logic and the FND scan driver.

Parameters:
- DATA_W, 14, width of the binary input.
- DIGITS, 4, number of BCD digits produced (DIGITS >= 1).
- SEL_W, $clog2(DIGITS) (minimum 1), width of the digit-select input.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  conversion request, sampled in IDLE only.
- i_data  in  DATA_W  binary value, captured on the accepted-start edge.
- i_fndDigit  in  SEL_W  digit select for o_fndData (0 = ones).
- o_busy  out  1  high while a conversion is in progress.
- o_done  out  1  one-cycle pulse when a new result is valid.
- o_bcd  out  4*DIGITS  registered packed BCD result; digit k is at bits [4k+3:4k].
- o_blank  out  DIGITS  leading-zero blank mask; bit k = 1 means digit k is blanked.
- o_overflow  out  1  registered flag: the last input exceeded 10^DIGITS-1.
- o_fndData  out  4  digit of o_bcd selected by i_fndDigit (combinational mux of registered data).

Behaviour:
- Reset (i_reset = 0, asynchronous): state = IDLE.
  - o_busy = 0, o_done = 0, o_bcd = 0, o_overflow = 0.
  - o_blank = all ones except bit 0, so 0 is displayed as "0".
  - Internal shift and count registers clear.
  - A reset during CONV aborts the conversion; no done pulse follows.
- FSM states: IDLE, CONV, DONE.
- IDLE, when i_start = 1 on a clock edge:
  - Capture i_data into the shift register; clear the BCD accumulator; bit counter = DATA_W.
  - If i_data > 10^DIGITS-1, latch ovf_pending = 1 and load the value 10^DIGITS-1 instead (saturation).
  - Next state = CONV; o_busy = 1 from that edge.
- CONV, each edge:
  - Every BCD digit >= 5 gets +3.
  - The {BCD, shift} register then shifts left 1.
  - The counter decrements.
  - When the counter reaches 0 after the shift, next state = DONE.
- DONE, one cycle:
  - On entry, o_bcd, o_blank and o_overflow update from the accumulator and ovf_pending.
  - o_done = 1 and o_busy = 0 for this cycle.
  - Next state = IDLE.
- Latency: o_done is high exactly DATA_W+1 clock cycles after the edge that accepted i_start.
  - Back-to-back throughput: one result per DATA_W+2 cycles.
- i_start while in CONV or DONE is ignored: not queued, no effect on the running conversion.
- o_bcd, o_blank and o_overflow hold the previous result until the next DONE. They never show intermediate values.
- Blank rule: for k >= 1, bit k = 1 iff digit k and all higher digits are 0. Bit 0 is always 0.
- o_fndData:
  - Equals o_bcd[4*i_fndDigit +: 4].
  - If i_fndDigit >= DIGITS, o_fndData = 0.
  - Updates with i_fndDigit in the same cycle, with no latch inference.
- All BCD arithmetic uses 4-bit digit slices. Add-3 carries never propagate across slices.

Test Plan:
- Reset, then pulse start with i_data = 1234 -> o_done pulses exactly 15 cycles after the start edge; o_bcd = 16'h1234, o_blank = 4'b0000, o_overflow = 0; i_fndDigit = 0..3 gives o_fndData = 4, 3, 2, 1.
- i_data = 7, then i_data = 0 -> o_bcd = 16'h0007 with o_blank = 4'b1110, then o_bcd = 16'h0000 with o_blank = 4'b1110.
- i_data = 16383 -> o_bcd = 16'h9999, o_overflow = 1; a following conversion of 9999 gives o_bcd = 16'h9999, o_overflow = 0.
- Convert 305; pulse i_start with i_data = 42 at cycle 5 of that conversion -> single done pulse, o_bcd = 16'h0305, o_blank = 4'b1000; o_busy stays high throughout and the second start is dropped.
- Assert i_reset at cycle 8 of converting 4321 -> o_busy = 0 and o_bcd = 0 immediately (asynchronous); no o_done pulse; a fresh start after release converts correctly.
- Parameter sweep DATA_W = 8, DIGITS = 3 with exhaustive inputs 0..255 -> o_bcd matches a reference decimal split; o_overflow never set; latency 9 cycles.
